shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle shift controller that sequences a one-bit shift step to build
//   an N-bit shift. Shifts left, right logical or right arithmetic by AMOUNT
//   positions, one position per clock, under a start/busy/done handshake.
//   Sits beside the ALU as the shift-unit controller, for shifts by a variable amount.
// PARAMETERS
//   WIDTH  4                     operand/result width in bits (>=2)
//   AW     $clog2(WIDTH)+1       width of the amount port
// PORTS
//   clk      in   1      single clock, rising-edge
//   rst_n    in   1      asynchronous, active-low reset
//   start    in   1      request: capture operands, begin shift (honoured only when idle)
//   dir      in   1      0 = shift left, 1 = shift right
//   arith    in   1      1 = arithmetic right (sign fill); ignored when dir=0
//   operand  in   WIDTH  value to shift
//   amount   in   AW     shift distance
//   busy     out  1      high while the controller is in SHIFT
//   done     out  1      single-cycle pulse: result/carry/zero valid
//   result   out  WIDTH  shifted value, held until next accepted start
//   carry    out  1      last bit shifted out (0 if amount==0)
//   zero     out  1      result == 0
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, carry=0, zero=1.
//   States: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 latches operand into the working register and dir/arith.
//     Remaining count = min(amount, WIDTH); amount>=WIDTH saturates to WIDTH.
//     count==0 -> DONE next cycle, result=operand, carry=0.
//     count>0 -> SHIFT next cycle.
//   SHIFT: busy=1. Each cycle performs one 1-bit step on the working register.
//     Left: shift in 0 at LSB; carry<=MSB.
//     Right logical: shift in 0 at MSB; carry<=LSB.
//     Right arithmetic: shift in the MSB at the MSB; carry<=LSB.
//     Decrement count; when count reaches 0, go to DONE.
//   DONE: done=1 for exactly one cycle, busy=0, then IDLE.
//     result/carry/zero are registered and stay stable until the next accepted start.
//   Latency: done is high in cycle k+1 after the start cycle, where k=min(amount,WIDTH).
//     Example: amount=0 gives done one cycle after start.
//   start while SHIFT or DONE: ignored; no queuing, and operand changes have no effect.
//   start in the cycle where done=1: ignored. It is accepted only in IDLE.
//   Inputs dir/arith/operand/amount are sampled only on the accepting cycle.
//   Reset mid-operation: abort immediately to the reset values; no done pulse.
//   zero is computed from the registered result and updates with it.
// STRUCTURE
//   shift_pkg: typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shift_state_t;
//     localparams DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
//   Sub-module shift_step: combinational 1-bit shifter (in: value, dir, arith;
//     out: shifted value, bit_out), instantiated once inside the sequencer.
//   The sequencer holds the FSM, count register and working/result registers.
// TESTING  (WIDTH=4, AW=3)
//   1. Right logical: operand=1011, amount=2, dir=1, arith=0 ->
//      done in 3rd cycle after start; result=0010, carry=1, zero=0.
//   2. Right arithmetic: operand=1011, amount=1, dir=1, arith=1 ->
//      done 2 cycles after start; result=1101, carry=1.
//   3. Left: operand=0011, amount=3, dir=0 -> busy high 3 cycles;
//      result=1000, carry=1.
//   4. Saturation: operand=1011, amount=7, right logical -> 4 shift cycles;
//      result=0000, carry=1, zero=1. Amount=0 -> result=1011, carry=0,
//      done 1 cycle after start.
//   5. start pulsed during SHIFT with a different operand -> ignored;
//      scenario 1 result is unchanged and there is exactly one done pulse.
//   6. rst_n low during the 2nd SHIFT cycle -> busy=0, result=0, zero=1
//      immediately; no done pulse. A new start after release completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift controller.
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shifter: left, right logical or right arithmetic.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dir,
    input  logic             i_arith,
    output logic [WIDTH-1:0] o_value_c,
    output logic             o_bit_out_c
);

    always_comb begin
        o_value_c   = i_value;
        o_bit_out_c = 1'b0;
        if (i_dir == DIR_RIGHT) begin
            // Arithmetic fill replicates the sign bit; logical fill is zero.
            o_value_c   = {i_arith & i_value[WIDTH-1], i_value[WIDTH-1:1]};
            o_bit_out_c = i_value[0];
        end else begin
            o_value_c   = {i_value[WIDTH-2:0], 1'b0};
            o_bit_out_c = i_value[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Shift-unit controller: builds an N-position shift from repeated 1-bit steps
// under a start/busy/done handshake.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic [WIDTH-1:0] operand,
    input  logic [AW-1:0]    amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    shift_state_t     r_state;
    shift_state_t     w_state_nxt;

    logic [AW-1:0]    r_count;
    logic [AW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_work_nxt;
    logic             r_cbit;
    logic             w_cbit_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_arith;
    logic             w_arith_nxt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    logic [AW-1:0]    w_amount_sat;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_bit;
    logic             w_enter_done;

    assign w_amount_sat = (amount >= AW'(WIDTH)) ? AW'(WIDTH) : amount;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_value     (r_work),
        .i_dir       (r_dir),
        .i_arith     (r_arith),
        .o_value_c   (w_step_val),
        .o_bit_out_c (w_step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and working-register update; start is honoured only in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_work_nxt  = r_work;
        w_cbit_nxt  = r_cbit;
        w_dir_nxt   = r_dir;
        w_arith_nxt = r_arith;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nxt  = operand;
                    w_dir_nxt   = dir;
                    w_arith_nxt = arith;
                    w_cbit_nxt  = 1'b0;
                    w_count_nxt = w_amount_sat;
                    w_state_nxt = (w_amount_sat == AW'(0)) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_work_nxt  = w_step_val;
                w_cbit_nxt  = w_step_bit;
                w_count_nxt = r_count - AW'(1);
                if (r_count == AW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    // Visible results only change when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_work   <= '0;
            r_cbit   <= 1'b0;
            r_dir    <= DIR_LEFT;
            r_arith  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_work  <= w_work_nxt;
            r_cbit  <= w_cbit_nxt;
            r_dir   <= w_dir_nxt;
            r_arith <= w_arith_nxt;
            r_busy  <= (w_state_nxt == S_SHIFT);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_enter_done) begin
                r_result <= w_work_nxt;
                r_carry  <= w_cbit_nxt;
                r_zero   <= (w_work_nxt == '0);
            end
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;

endmodule
